// File: rtl/rw_array.sv
// rw_array: an array of DEPTH stateful registers, each COUNT_WIDTH bits wide.
// Every valid packet performs one atomic read-modify-write on the entry it
// selects. The update is read-only, write, add or subtract, and the operand
// comes from a constant/packet-field mux. Two pipeline stages accept one
// packet per cycle. Same-index forwarding makes back-to-back packets on one
// entry behave strictly in order.
//
// Optional feature macro: RW_ARRAY_SATURATE_EN. When it is defined, add
// clamps at all-ones and subtract clamps at zero. When it is undefined, both
// wrap modulo 2^COUNT_WIDTH.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   i__valid     packet present this cycle
//   i__index     state entry selector
//   i__opcode    00 read-only, 01 write, 10 add, 11 subtract
//   i__constant  constant operand
//   i__pkt_1     packet-field operand
//   i__sel       operand select: 0 = i__constant, 1 = i__pkt_1
//   o__valid     result valid (two cycles after the input)
//   o__read      entry value before the update
//   o__write     entry value after the update
//   o__err       index out of range (index >= DEPTH)
module rw_array #(
  parameter int COUNT_WIDTH = 32,
  parameter int DEPTH       = 16,
  parameter int INDEX_WIDTH = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i__valid,
  input  logic [INDEX_WIDTH-1:0] i__index,
  input  logic [1:0]             i__opcode,
  input  logic [COUNT_WIDTH-1:0] i__constant,
  input  logic [COUNT_WIDTH-1:0] i__pkt_1,
  input  logic                   i__sel,
  output logic                   o__valid,
  output logic [COUNT_WIDTH-1:0] o__read,
  output logic [COUNT_WIDTH-1:0] o__write,
  output logic                   o__err
);

  localparam logic [INDEX_WIDTH:0] DEPTH_EXT = (INDEX_WIDTH + 1)'(DEPTH);

  logic [COUNT_WIDTH-1:0] state [DEPTH];

  logic                   s1_valid;
  logic [INDEX_WIDTH-1:0] s1_index;
  logic [1:0]             s1_opcode;
  logic [COUNT_WIDTH-1:0] s1_operand;
  logic [COUNT_WIDTH-1:0] s1_rdata;
  logic                   s1_err;
  logic [COUNT_WIDTH-1:0] s1_new;
  logic                   s1_writes;

  logic                   in_err;
  logic [COUNT_WIDTH-1:0] operand;
  logic                   fwd_hit;
  logic [COUNT_WIDTH-1:0] rdata_next;

  // Zero-extend the index by one bit so that the range check stays valid
  // when DEPTH is an exact power of two.
  assign in_err  = ({1'b0, i__index} >= DEPTH_EXT);
  assign operand = i__sel ? i__pkt_1 : i__constant;

  // Only a valid, in-range op that modifies the entry can be a forwarding
  // source. A read-only op leaves the array exactly as it was.
  assign s1_writes = s1_valid && !s1_err && (s1_opcode != 2'b00);
  assign fwd_hit   = s1_writes && (s1_index == i__index);

  // The op in S1 lands its write at the same edge this read is captured,
  // so its new value must be taken instead of the stale array contents.
  assign rdata_next = fwd_hit ? s1_new :
                      (in_err ? '0 : state[i__index]);

`ifdef RW_ARRAY_SATURATE_EN
  logic [COUNT_WIDTH:0] add_wide;
  assign add_wide = {1'b0, s1_rdata} + {1'b0, s1_operand};
`endif

  // The new entry value is computed from the value captured in S1.
  always_comb begin
    s1_new = s1_rdata;
    case (s1_opcode)
      2'b01: s1_new = s1_operand;
`ifdef RW_ARRAY_SATURATE_EN
      2'b10: s1_new = add_wide[COUNT_WIDTH] ? '1 : add_wide[COUNT_WIDTH-1:0];
      2'b11: s1_new = (s1_operand > s1_rdata) ? '0 : (s1_rdata - s1_operand);
`else
      2'b10: s1_new = s1_rdata + s1_operand;
      2'b11: s1_new = s1_rdata - s1_operand;
`endif
      default: s1_new = s1_rdata;
    endcase
  end

  // Stage 1 capture. Reset clears the valid bit, so an op that is in flight
  // is dropped and inputs presented during reset are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_index   <= '0;
      s1_opcode  <= 2'b00;
      s1_operand <= '0;
      s1_rdata   <= '0;
      s1_err     <= 1'b0;
    end else begin
      s1_valid   <= i__valid;
      s1_index   <= i__index;
      s1_opcode  <= i__opcode;
      s1_operand <= operand;
      s1_rdata   <= rdata_next;
      s1_err     <= in_err;
    end
  end

  // State array write-back. This happens at the second stage edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        state[i] <= '0;
      end
    end else if (s1_writes) begin
      state[s1_index] <= s1_new;
    end
  end

  // Result registers. A bubble clears o__valid and leaves the data and
  // error outputs holding their last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      o__valid <= 1'b0;
      o__read  <= '0;
      o__write <= '0;
      o__err   <= 1'b0;
    end else if (s1_valid) begin
      o__valid <= 1'b1;
      o__err   <= s1_err;
      o__read  <= s1_err ? '0 : s1_rdata;
      o__write <= s1_err ? '0 : s1_new;
    end else begin
      o__valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rw_array.sv
// tb_rw_array: directed self-checking bench for rw_array. The DUT is built
// with DEPTH=12, so some indices are out of range and the error path can be
// reached. Inputs change on the falling edge and outputs are sampled on the
// falling edge.
module tb_rw_array;

  localparam int CW = 32;
  localparam int DP = 12;
  localparam int IW = 4;

`ifdef RW_ARRAY_SATURATE_EN
  localparam logic [CW-1:0] ADD7_EXP = 32'hFFFF_FFFF;
  localparam logic [CW-1:0] SUB0_EXP = 32'h0000_0000;
`else
  localparam logic [CW-1:0] ADD7_EXP = 32'h0000_0001;
  localparam logic [CW-1:0] SUB0_EXP = 32'hFFFF_FFFF;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [IW-1:0] in_index;
  logic [1:0]    in_opcode;
  logic [CW-1:0] in_constant;
  logic [CW-1:0] in_pkt;
  logic          in_sel;
  logic          out_valid;
  logic [CW-1:0] out_read;
  logic [CW-1:0] out_write;
  logic          out_err;

  int checkCount;
  int passCount;
  logic [CW-1:0] model [DP];

  rw_array #(.COUNT_WIDTH(CW), .DEPTH(DP)) dut (
    .clk        (clk),
    .rst        (rst),
    .i__valid   (in_valid),
    .i__index   (in_index),
    .i__opcode  (in_opcode),
    .i__constant(in_constant),
    .i__pkt_1   (in_pkt),
    .i__sel     (in_sel),
    .o__valid   (out_valid),
    .o__read    (out_read),
    .o__write   (out_write),
    .o__err     (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one input cycle, then return at the next falling edge.
  task automatic applyStimulus(input logic v, input logic [IW-1:0] idx,
                               input logic [1:0] op, input logic [CW-1:0] k,
                               input logic [CW-1:0] p, input logic s);
    in_valid    = v;
    in_index    = idx;
    in_opcode   = op;
    in_constant = k;
    in_pkt      = p;
    in_sel      = s;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 2'b00, '0, '0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [CW-1:0] got,
                             input logic [CW-1:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  task automatic checkResult(input string tag, input logic v,
                             input logic [CW-1:0] r, input logic [CW-1:0] w,
                             input logic e);
    checkOutput({tag, ".valid"}, {31'b0, out_valid}, {31'b0, v});
    checkOutput({tag, ".read"},  out_read,  r);
    checkOutput({tag, ".write"}, out_write, w);
    checkOutput({tag, ".err"},   {31'b0, out_err}, {31'b0, e});
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    for (int i = 0; i < DP; i++) model[i] = '0;
    rst = 1'b1;
    in_valid = 1'b0; in_index = '0; in_opcode = 2'b00;
    in_constant = '0; in_pkt = '0; in_sel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkResult("reset", 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;

    // Read-only of a fresh entry.
    applyStimulus(1'b1, 4'd3, 2'b00, 32'h0, 32'h0, 1'b0);
    idle();
    checkResult("read3", 1'b1, 32'h0, 32'h0, 1'b0);

    // Write through the packet-field operand, then read it back later.
    applyStimulus(1'b1, 4'd5, 2'b01, 32'h11, 32'hA5, 1'b1);
    idle();
    checkResult("write5", 1'b1, 32'h0, 32'hA5, 1'b0);
    model[5] = 32'hA5;
    applyStimulus(1'b1, 4'd5, 2'b00, 32'h0, 32'h0, 1'b0);
    idle();
    checkResult("read5", 1'b1, 32'hA5, 32'hA5, 1'b0);

    // Four back-to-back adds on one index exercise forwarding.
    applyStimulus(1'b1, 4'd2, 2'b10, 32'h1, 32'h77, 1'b0);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1'b1, 4'd2, 2'b10, 32'h1, 32'h77, 1'b0);
      checkResult($sformatf("add2_%0d", n), 1'b1, CW'(n), CW'(n + 1), 1'b0);
    end
    idle();
    checkResult("add2_3", 1'b1, 32'h3, 32'h4, 1'b0);
    model[2] = 32'h4;
    idle();
    checkResult("bubble_hold", 1'b0, 32'h3, 32'h4, 1'b0);

    // Overflow and underflow, including forwarding of the result.
    applyStimulus(1'b1, 4'd7, 2'b01, 32'h0, 32'hFFFF_FFFF, 1'b1);
    idle();
    checkResult("write7", 1'b1, 32'h0, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(1'b1, 4'd7, 2'b10, 32'h2, 32'h0, 1'b0);
    applyStimulus(1'b1, 4'd7, 2'b00, 32'h0, 32'h0, 1'b0);
    checkResult("add7_ovf", 1'b1, 32'hFFFF_FFFF, ADD7_EXP, 1'b0);
    applyStimulus(1'b1, 4'd0, 2'b11, 32'h1, 32'h0, 1'b0);
    checkResult("read7_fwd", 1'b1, ADD7_EXP, ADD7_EXP, 1'b0);
    idle();
    checkResult("sub0_udf", 1'b1, 32'h0, SUB0_EXP, 1'b0);
    model[7] = ADD7_EXP;
    model[0] = SUB0_EXP;

    // An out-of-range write must flag an error and leave the array untouched.
    applyStimulus(1'b1, 4'd13, 2'b01, 32'h55, 32'h0, 1'b0);
    idle();
    checkResult("oor13", 1'b1, 32'h0, 32'h0, 1'b1);
    applyStimulus(1'b1, 4'd12, 2'b01, 32'h66, 32'h0, 1'b0);
    idle();
    checkResult("oor12", 1'b1, 32'h0, 32'h0, 1'b1);
    applyStimulus(1'b1, 4'd0, 2'b00, 32'h0, 32'h0, 1'b0);
    for (int i = 1; i < DP; i++) begin
      applyStimulus(1'b1, IW'(i), 2'b00, 32'h0, 32'h0, 1'b0);
      checkResult($sformatf("scan%0d", i - 1), 1'b1, model[i-1], model[i-1], 1'b0);
    end
    idle();
    checkResult($sformatf("scan%0d", DP - 1), 1'b1, model[DP-1], model[DP-1], 1'b0);

    // Reset while a write is in flight drops that write.
    applyStimulus(1'b1, 4'd1, 2'b01, 32'h9, 32'h0, 1'b0);
    rst = 1'b1;
    idle();
    checkResult("rst_drop", 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b1, 4'd1, 2'b00, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 4'd5, 2'b00, 32'h0, 32'h0, 1'b0);
    checkResult("post_rst1", 1'b1, 32'h0, 32'h0, 1'b0);
    idle();
    checkResult("post_rst5", 1'b1, 32'h0, 32'h0, 1'b0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
